// File: rtl/xcorr_ring_buf.sv
// Multi-channel circular sample history for the Rx cross-correlator.
// Stores the last DEPTH samples of NUM_CH channels and returns any past sample by lag.
module xcorr_ring_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int NUM_CH     = 2,
    parameter int OUT_REG    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    input  logic                           rd_req,
    input  logic [$clog2(DEPTH)-1:0]       rd_lag,
    output logic                           out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
    output logic                           out_empty,
    output logic [$clog2(DEPTH):0]         fill,
    output logic                           full
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = NUM_CH * DATA_WIDTH;
    localparam logic [AW-1:0] WP_ONE   = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW:0]   fill_q;
    logic [AW-1:0] rd_addr;
    logic          we;
    logic          s1_valid, s1_empty;
    logic          s2_valid, s2_empty;
    logic [W-1:0]  ram_q;
    logic [W-1:0]  s2_data;
    logic [W-1:0]  s2_out;

    // A write that coincides with clear is dropped along with the rest of the history.
    assign we      = in_valid & ~clear;
    assign rd_addr = wp - WP_ONE - rd_lag;
    assign fill    = fill_q;
    assign full    = (fill_q == FILL_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp     <= '0;
            fill_q <= '0;
        end else if (clear) begin
            wp     <= '0;
            fill_q <= '0;
        end else if (in_valid) begin
            wp <= wp + WP_ONE;
            if (fill_q != FILL_MAX) fill_q <= fill_q + FILL_ONE;
        end
    end

    // The RAM is read on the request edge (read-first), so the oldest sample is fetched
    // before a simultaneous write can overwrite it; the second register keeps latency at 2.
    // NOTE: RAM and its data registers carry no reset so they map onto block RAM; valids guard them.
    always_ff @(posedge clk) begin
        if (we) mem[wp] <= in_data;
        ram_q   <= mem[rd_addr];
        s2_data <= ram_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_empty <= 1'b0;
            s2_valid <= 1'b0;
            s2_empty <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s1_empty <= 1'b0;
            s2_valid <= 1'b0;
            s2_empty <= 1'b0;
        end else begin
            s1_valid <= rd_req;
            s1_empty <= ({1'b0, rd_lag} >= fill_q);
            s2_valid <= s1_valid;
            s2_empty <= s1_empty;
        end
    end

    assign s2_out = (s2_valid && !s2_empty) ? s2_data : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic         s3_valid, s3_empty;
            logic [W-1:0] s3_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s3_valid <= 1'b0;
                    s3_empty <= 1'b0;
                    s3_data  <= '0;
                end else if (clear) begin
                    s3_valid <= 1'b0;
                    s3_empty <= 1'b0;
                    s3_data  <= '0;
                end else begin
                    s3_valid <= s2_valid;
                    s3_empty <= s2_valid & s2_empty;
                    s3_data  <= s2_out;
                end
            end

            assign out_valid = s3_valid;
            assign out_empty = s3_empty;
            assign out_data  = s3_data;
        end else begin : g_out_comb
            assign out_valid = s2_valid;
            assign out_empty = s2_valid & s2_empty;
            assign out_data  = s2_out;
        end
    endgenerate

endmodule

// File: tb/tb_xcorr_ring_buf.sv
// Scoreboard bench for xcorr_ring_buf: two instances (OUT_REG=0 and 1, DEPTH=8) share one
// stimulus stream and are checked against a queue-based history model.
module tb_xcorr_ring_buf;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int NCH   = 2;
    localparam int W     = DW * NCH;

    typedef struct {
        int          req_edge;
        logic [W-1:0] data;
        logic        empty;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          rd_req;
    logic [2:0]    rd_lag;
    logic [1:0]    ov, oe, fullv;
    logic [W-1:0]  od [2];
    logic [3:0]    fl [2];

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    logic [W-1:0] hist [$];   // newest sample at index 0
    exp_t         sb [2][$];

    xcorr_ring_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .rd_req(rd_req), .rd_lag(rd_lag), .out_valid(ov[0]), .out_data(od[0]),
        .out_empty(oe[0]), .fill(fl[0]), .full(fullv[0])
    );

    xcorr_ring_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .rd_req(rd_req), .rd_lag(rd_lag), .out_valid(ov[1]), .out_data(od[1]),
        .out_empty(oe[1]), .fill(fl[1]), .full(fullv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int id);
        return (id == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic mon(input int id, input logic v, input logic [W-1:0] d, input logic e);
        exp_t x;
        if (v) begin
            if (sb[id].size() == 0) begin
                check($sformatf("dut%0d_unexpected_valid", id), 1, 0);
            end else begin
                x = sb[id].pop_front();
                check($sformatf("dut%0d_data", id), d, x.data);
                check($sformatf("dut%0d_empty", id), W'(e), W'(x.empty));
                check($sformatf("dut%0d_latency", id), W'(cyc + 1 - x.req_edge), W'(lat(id)));
            end
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i, ov[i], od[i], oe[i]);
    end

    task automatic check_fill();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_fill", i), W'(fl[i]), W'(hist.size()));
            check($sformatf("dut%0d_full", i), W'(fullv[i]), W'(hist.size() == DEPTH));
        end
    endtask

    // One clock of stimulus, called and returning at a falling edge.
    task automatic step(input bit wv, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input bit rq, input int lag, input bit clr);
        int   e_n;
        exp_t x;
        in_valid = wv;
        in_data  = {d1, d0};
        rd_req   = rq;
        rd_lag   = 3'(lag);
        clear    = clr;
        e_n      = cyc + 1;
        if (clr) begin
            // Any request whose output would appear at or after the clear edge is flushed.
            for (int i = 0; i < 2; i++)
                while (sb[i].size() > 0 && sb[i][$].req_edge + lat(i) - 1 >= e_n)
                    void'(sb[i].pop_back());
        end else if (rq) begin
            x.req_edge = e_n;
            x.empty    = (lag >= hist.size());
            x.data     = x.empty ? '0 : hist[lag];
            for (int i = 0; i < 2; i++) sb[i].push_back(x);
        end
        @(posedge clk);
        if (clr) begin
            hist.delete();
        end else if (wv) begin
            hist.push_front({d1, d0});
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        @(negedge clk);
        check_fill();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; rd_req = 1'b0; rd_lag = '0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_dut%0d_valid", i), W'(ov[i]), 0);
            check($sformatf("reset_dut%0d_empty", i), W'(oe[i]), 0);
            check($sformatf("reset_dut%0d_data", i), od[i], 0);
            check($sformatf("reset_dut%0d_fill", i), W'(fl[i]), 0);
            check($sformatf("reset_dut%0d_full", i), W'(fullv[i]), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: samples 1..5, then lags 0,1,4,5 back-to-back.
        for (int i = 1; i <= 5; i++) step(1, i, 100 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 5, 0);
        idle(4);

        // Wrap: 11 writes into 8 entries, then read every lag.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 11; i++) step(1, i, 100 + i, 0, 0, 0);
        for (int l = 0; l < DEPTH; l++) step(0, 0, 0, 1, l, 0);
        idle(4);

        // Same-cycle write and lag-0 request.
        step(0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) step(1, i, 100 + i, 0, 0, 0);
        step(1, 9, 109, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(4);

        // Clear with reads in flight and a concurrent write.
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        step(1, 55, 155, 1, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        idle(4);

        // Asynchronous reset between edges with outputs pending.
        step(1, 3, 103, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        in_valid = 1'b0; rd_req = 1'b0; clear = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("async_rst_dut%0d_valid", i), W'(ov[i]), 0);
            check($sformatf("async_rst_dut%0d_data", i), od[i], 0);
            check($sformatf("async_rst_dut%0d_empty", i), W'(oe[i]), 0);
            check($sformatf("async_rst_dut%0d_fill", i), W'(fl[i]), 0);
            sb[i].delete();
        end
        hist.delete();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step(1, 7, 107, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        idle(4);

        // Randomized traffic.
        for (int k = 0; k < 600; k++)
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, DEPTH - 1),
                 $urandom_range(0, 39) == 0);

        // Drain and make sure every expected response came out.
        for (int k = 0; k < 20 && (sb[0].size() > 0 || sb[1].size() > 0); k++) idle(1);
        for (int i = 0; i < 2; i++)
            check($sformatf("drain_dut%0d_pending", i), W'(sb[i].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
